// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtree_pkg
// Description : Shared parameter defaults and the state type for the
//               decision-tree feature loader.
// Revision    : 1.0 - initial release
// ============================================================================
package dtree_pkg;

    localparam int c_num_feat = 20;
    localparam int c_feat_w   = 8;
    localparam int c_class_w  = 2;
    localparam int c_settle   = 2;

    // Loader control states: collecting beats, waiting on the tree, holding the result
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dtree_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dtree_settle_cnt
// Description : Loadable down-counter; term flags the final settle cycle
//               (count == 1) so the class can be captured on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_settle_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             term
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign term = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/dtree_feature_loader.sv
`default_nettype none
// ============================================================================
// Module      : dtree_feature_loader
// Description : Collects one feature per stream beat into a parallel bus for
//               the combinational tree, waits SETTLE cycles, captures the
//               class and offers it on a valid/ready output.
//               Optional: DTREE_LOADER_PARITY_EN adds s_parity with an
//               even-parity check folded into the frame error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int NUM_FEAT = c_num_feat,
    parameter int FEAT_W   = c_feat_w,
    parameter int CLASS_W  = c_class_w,
    parameter int SETTLE   = c_settle
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FEAT_W-1:0]          s_data,
    input  logic                       s_last,
`ifdef DTREE_LOADER_PARITY_EN
    input  logic                       s_parity,
`endif
    output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]         cls_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CLASS_W-1:0]         m_class,
    output logic                       m_err
);

    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_FEAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [FEAT_W-1:0]   r_slot [NUM_FEAT];
    logic                r_frame_err;
    logic                w_beat;
    logic                w_at_last;
    logic                w_short;
    logic                w_done_load;
    logic                w_par_err;
    logic                w_cnt_term;
    logic                w_handshake;

    assign s_ready     = (r_state == ST_LOAD);
    assign w_beat      = s_valid && s_ready;
    assign w_at_last   = (r_idx == c_last_idx);
    assign w_short     = w_beat && s_last && !w_at_last;
    assign w_done_load = w_beat && (w_at_last || s_last);
    assign w_handshake = (r_state == ST_HOLD) && m_valid && m_ready;

`ifdef DTREE_LOADER_PARITY_EN
    assign w_par_err = w_beat && (^{s_data, s_parity});
`else
    assign w_par_err = 1'b0;
`endif

    dtree_settle_cnt #(
        .WIDTH (CNT_W)
    ) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_done_load),
        .load_val (CNT_W'(SETTLE)),
        .en       (r_state == ST_SETTLE),
        .term     (w_cnt_term)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:   if (w_done_load) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_cnt_term)  w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_handshake) w_state_nxt = ST_LOAD;
            default:   w_state_nxt = ST_LOAD;
        endcase
    end

    // Feature bank, slot index, sticky frame error and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_frame_err <= 1'b0;
            m_valid     <= 1'b0;
            m_class     <= '0;
            m_err       <= 1'b0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_beat) begin
                r_idx       <= r_idx + 1'b1;
                r_frame_err <= r_frame_err | w_short | w_par_err;
                // Store the current slot; a short frame also blanks every later slot
                for (int i = 0; i < NUM_FEAT; i++) begin
                    if (IDX_W'(i) == r_idx) begin
                        r_slot[i] <= s_data;
                    end else if (w_short && (IDX_W'(i) > r_idx)) begin
                        r_slot[i] <= '0;
                    end
                end
            end
            if ((r_state == ST_SETTLE) && w_cnt_term) begin
                m_class <= cls_in;
                m_valid <= 1'b1;
                m_err   <= r_frame_err;
            end
            if (w_handshake) begin
                m_valid     <= 1'b0;
                m_err       <= 1'b0;
                r_idx       <= '0;
                r_frame_err <= 1'b0;
            end
        end
    end

    // Flatten the bank onto the tree input bus
    generate
        for (genvar g = 0; g < NUM_FEAT; g++) begin : g_bus
            assign feat_bus[g*FEAT_W +: FEAT_W] = r_slot[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dtree_feature_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtree_feature_loader
// Description : Self-checking bench for dtree_feature_loader: table of frames,
//               scoreboard of expected results, plus back-pressure and
//               mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_feature_loader;

    localparam int NF  = 20;
    localparam int FW  = 8;
    localparam int CW  = 2;
    localparam int ST  = 2;
    localparam int BW  = NF * FW;
`ifdef DTREE_LOADER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [FW-1:0] s_data;
    logic          s_last;
    logic          s_parity;
    logic [BW-1:0] feat_bus;
    logic [CW-1:0] cls_in;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] m_class;
    logic          m_err;

    dtree_feature_loader #(
        .NUM_FEAT (NF),
        .FEAT_W   (FW),
        .CLASS_W  (CW),
        .SETTLE   (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
`ifdef DTREE_LOADER_PARITY_EN
        .s_parity (s_parity),
`endif
        .feat_bus (feat_bus),
        .cls_in   (cls_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .m_err    (m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         nbeats;
        bit         last_full;
        logic [1:0] cls;
        int         bad_idx;
    } vec_t;

    typedef struct {
        logic [CW-1:0] cls;
        logic          err;
        logic [BW-1:0] bus;
    } exp_t;

    exp_t          sb[$];
    logic [FW-1:0] model[NF];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < NF; i++) b[i*FW +: FW] = model[i];
        return b;
    endfunction

    // Result monitor: each handshake cycle pops one expected record
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("m_class", BW'(m_class), BW'(e.cls));
                chk("m_err", BW'(m_err), BW'(e.err));
                chk("feat_bus", feat_bus, e.bus);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [7:0] d, input logic lst, input logic bad);
        bit acc;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = lst;
        s_parity = (^d) ^ bad;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = s_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Drive a frame, update the bank model and queue the expected result
    task automatic run_frame(input vec_t v);
        exp_t e;
        for (int i = 0; i < v.nbeats; i++) begin
            logic       lst;
            logic [7:0] d;
            lst = (i == v.nbeats - 1) && ((v.nbeats < NF) || v.last_full);
            d   = v.base + 8'(i) * v.step;
            cls_in = (i == v.nbeats - 1) ? v.cls : ~v.cls;
            send_beat(d, lst, i == v.bad_idx);
            model[i] = d;
        end
        for (int j = v.nbeats; j < NF; j++) model[j] = '0;
        e.cls = v.cls;
        e.err = (v.nbeats < NF) || (PAR_EN && v.bad_idx >= 0 && v.bad_idx < v.nbeats);
        e.bus = model_bus();
        sb.push_back(e);
    endtask

    // Check m_valid rises exactly ST cycles after the final beat
    task automatic chk_latency();
        for (int k = 1; k <= ST; k++) begin
            @(posedge clk); #1;
            chk($sformatf("m_valid_lat%0d", k), BW'(m_valid), BW'(k == ST));
        end
    endtask

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] held_bus;
        vec_t          v;

        tbl[0] = '{8'h10, 8'h01, 20, 1'b0, 2'b10, -1};
        tbl[1] = '{8'hA0, 8'h01,  5, 1'b1, 2'b01, -1};
        tbl[2] = '{8'h55, 8'h03, 20, 1'b0, 2'b11, -1};
        tbl[3] = '{8'h33, 8'h00,  1, 1'b1, 2'b00, -1};
        tbl[4] = '{8'hF0, 8'h02, 19, 1'b1, 2'b10, -1};
        tbl[5] = '{8'h01, 8'h07, 20, 1'b1, 2'b01, -1};
        tbl[6] = '{8'h80, 8'h01, 20, 1'b0, 2'b11,  4};
        tbl[7] = '{8'h90, 8'h01, 20, 1'b0, 2'b00, -1};
        for (int i = 0; i < NF; i++) model[i] = '0;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        s_parity = 1'b0; cls_in = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_s_ready", BW'(s_ready), 1);
        chk("rst_m_valid", BW'(m_valid), 0);
        chk("rst_m_class", BW'(m_class), 0);
        chk("rst_m_err", BW'(m_err), 0);
        chk("rst_feat_bus", feat_bus, '0);
        @(posedge clk); #1;

        // Table-driven frames
        for (int t = 0; t < 8; t++) begin
            run_frame(tbl[t]);
            chk_latency();
            @(posedge clk); #1;
            chk("post_hs_s_ready", BW'(s_ready), 1);
        end

        // Back-pressure: result and bus must hold, no beats consumed
        v = '{8'h40, 8'h05, 20, 1'b0, 2'b01, -1};
        m_ready = 1'b0;
        run_frame(v);
        chk_latency();
        held_bus = feat_bus;
        chk("bp_bus_model", feat_bus, model_bus());
        s_valid = 1'b1; s_data = 8'hC0; s_last = 1'b0; s_parity = ^s_data;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_m_valid", BW'(m_valid), 1);
            chk("bp_m_class", BW'(m_class), BW'(v.cls));
            chk("bp_feat_bus", feat_bus, held_bus);
            chk("bp_s_ready", BW'(s_ready), 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_s_ready", BW'(s_ready), 1);
        chk("bp_hs_m_valid", BW'(m_valid), 0);
        chk("bp_bus_unchanged", feat_bus, held_bus);
        v = '{8'hC0, 8'h01, 20, 1'b0, 2'b10, -1};
        run_frame(v);
        chk_latency();
        @(posedge clk); #1;

        // Reset in the middle of a frame
        for (int i = 0; i < 7; i++) send_beat(8'hE0 + 8'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_feat_bus", feat_bus, '0);
        chk("mid_rst_m_valid", BW'(m_valid), 0);
        chk("mid_rst_s_ready", BW'(s_ready), 1);
        for (int i = 0; i < NF; i++) model[i] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        v = '{8'h21, 8'h01, 20, 1'b0, 2'b11, -1};
        run_frame(v);
        chk_latency();

        // Drain scoreboard
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", BW'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
